// File: rtl/lc3_fetch_unit_if.sv
// Bus bundle for the LC3 fetch unit: instruction-memory req/ack side, datapath
// valid/ready side and the redirect port. master = fetch unit, slave = its environment.
interface lc3_fetch_unit_if;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memAck;
  logic [15:0] memData;
  logic        instValid;
  logic [15:0] instData;
  logic [15:0] instAddr;
  logic        instReady;
  logic        redirect;
  logic [15:0] redirectAddr;

  modport master (
    output memReq, memAddr, instValid, instData, instAddr,
    input  memAck, memData, instReady, redirect, redirectAddr
  );

  modport slave (
    input  memReq, memAddr, instValid, instData, instAddr,
    output memAck, memData, instReady, redirect, redirectAddr
  );
endinterface

// File: rtl/lc3_fetch_unit.sv
// LC3 instruction fetch stage: sequential prefetch into a DEPTH-entry queue with redirect flush.
// Optional macro LC3_FETCH_BYPASS_EN forwards an ack straight to the datapath when the queue is empty.
module lc3_fetch_unit #(
  parameter logic [15:0] START_ADDR = 16'h3000,
  parameter int          DEPTH      = 4
) (
  input  logic               clk,
  input  logic               rst,
  lc3_fetch_unit_if.master   bus,
  output logic [1:0]         dbg_state
);

  // Handshakes: a memory request completes in any cycle with memReq && memAck
  // (memAddr held stable while memReq is high); an instruction transfers in any
  // cycle with instValid && instReady. redirect overrides both in its cycle.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_q, state_nx;
  logic [15:0]   fetch_pc_q, fetch_pc_nx;
  logic [15:0]   mem_addr_q, mem_addr_nx;
  logic [15:0]   q_addr [DEPTH];
  logic [15:0]   q_data [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q, count_nx;

  logic bypass, head_valid, pop, push, slot_free;

  always_comb begin
    bypass = 1'b0;
`ifdef LC3_FETCH_BYPASS_EN
    bypass = (count_q == '0) && (state_q == WAIT) && bus.memAck && !bus.redirect;
`endif
    head_valid    = (count_q != '0);
    bus.instValid = head_valid | bypass;
    bus.instData  = bypass ? bus.memData : q_data[rd_q];
    bus.instAddr  = bypass ? fetch_pc_q  : q_addr[rd_q];
    bus.memReq    = (state_q != IDLE);
    bus.memAddr   = mem_addr_q;
    dbg_state     = state_q;
  end

  // A bypassed word taken by the datapath in the same cycle never enters the queue.
  always_comb begin
    pop       = head_valid && bus.instReady;
    push      = (state_q == WAIT) && bus.memAck && !bus.redirect && !(bypass && bus.instReady);
    count_nx  = count_q + CW'(push) - CW'(pop);
    slot_free = (count_nx < CW'(DEPTH));
  end

  always_comb begin
    state_nx    = state_q;
    fetch_pc_nx = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect) begin
          fetch_pc_nx = bus.redirectAddr;
          state_nx    = WAIT;
        end else if (slot_free) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          fetch_pc_nx = bus.redirectAddr;
          state_nx    = bus.memAck ? WAIT : DROP;
        end else if (bus.memAck) begin
          fetch_pc_nx = fetch_pc_q + 16'd1;
          state_nx    = slot_free ? WAIT : IDLE;
        end
      end
      DROP: begin
        if (bus.redirect) fetch_pc_nx = bus.redirectAddr;
        if (bus.memAck)   state_nx    = WAIT;
      end
      default: state_nx = IDLE;
    endcase
    // While a dropped request is outstanding memAddr must keep its original value.
    mem_addr_nx = (state_nx == DROP) ? mem_addr_q : fetch_pc_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= START_ADDR;
      mem_addr_q <= START_ADDR;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      state_q    <= state_nx;
      fetch_pc_q <= fetch_pc_nx;
      mem_addr_q <= mem_addr_nx;
      if (bus.redirect) begin
        rd_q    <= '0;
        wr_q    <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          q_addr[wr_q] <= fetch_pc_q;
          q_data[wr_q] <= bus.memData;
          wr_q         <= wr_q + AW'(1);
        end
        if (pop) rd_q <= rd_q + AW'(1);
        count_q <= count_nx;
      end
    end
  end

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Directed self-checking bench for lc3_fetch_unit (default build, bypass disabled).
module tb_lc3_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  dbg_state;
  logic        auto_ack = 1'b0;
  logic        man_ack  = 1'b0;
  logic [15:0] man_data = 16'h0000;
  int          checks = 0;
  int          errors = 0;

  lc3_fetch_unit_if bus ();

  lc3_fetch_unit #(.START_ADDR(16'h3000), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Memory model: in auto mode it acks every request at once with mem[a] = a - 3000.
  always_comb begin
    bus.memAck  = auto_ack ? bus.memReq : man_ack;
    bus.memData = auto_ack ? (bus.memAddr - 16'h3000) : man_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ack_mode, input logic ready);
    rst = 1'b1;
    auto_ack = ack_mode;
    man_ack = 1'b0;
    bus.instReady = ready;
    bus.redirect = 1'b0;
    bus.redirectAddr = 16'h0000;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset(1'b1, 1'b1);
    checks++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL rst_memReq got %b exp 0", bus.memReq); end
    checks++; if (bus.memAddr !== 16'h3000) begin errors++; $display("FAIL rst_memAddr got %h exp 3000", bus.memAddr); end
    checks++; if (bus.instValid !== 1'b0) begin errors++; $display("FAIL rst_instValid got %b exp 0", bus.instValid); end
    checks++; if (bus.instData !== 16'h0000) begin errors++; $display("FAIL rst_instData got %h exp 0000", bus.instData); end
    checks++; if (bus.instAddr !== 16'h0000) begin errors++; $display("FAIL rst_instAddr got %h exp 0000", bus.instAddr); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    tick();
    checks++; if (bus.memReq !== 1'b1) begin errors++; $display("FAIL stream_req1 got %b exp 1", bus.memReq); end
    checks++; if (bus.memAddr !== 16'h3000) begin errors++; $display("FAIL stream_addr1 got %h exp 3000", bus.memAddr); end
    checks++; if (bus.instValid !== 1'b0) begin errors++; $display("FAIL stream_valid1 got %b exp 0", bus.instValid); end
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.instValid !== 1'b1 || bus.instAddr !== 16'h3000 + 16'(i) || bus.instData !== 16'(i)) begin
        errors++;
        $display("FAIL stream_head%0d got v=%b a=%h d=%h exp v=1 a=%h d=%h", i, bus.instValid,
                 bus.instAddr, bus.instData, 16'h3000 + 16'(i), 16'(i));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int fetches;
    do_reset(1'b1, 1'b0);
    rst = 1'b0;
    fetches = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.memReq && bus.memAck) fetches++;
    end
    checks++; if (fetches !== 4) begin errors++; $display("FAIL bp_fetches got %0d exp 4", fetches); end
    checks++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL bp_req got %b exp 0", bus.memReq); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL bp_state got %0d exp 0", dbg_state); end
    bus.instReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.instValid !== 1'b1 || bus.instAddr !== 16'h3000 + 16'(i) || bus.instData !== 16'(i)) begin
        errors++;
        $display("FAIL bp_head%0d got v=%b a=%h d=%h exp v=1 a=%h d=%h", i, bus.instValid,
                 bus.instAddr, bus.instData, 16'h3000 + 16'(i), 16'(i));
      end
      tick();
    end
  endtask

  task automatic test_latency();
    do_reset(1'b0, 1'b0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.memReq !== 1'b1 || bus.memAddr !== 16'h3000 || bus.instValid !== 1'b0) begin
        errors++;
        $display("FAIL lat_wait%0d got req=%b a=%h v=%b exp req=1 a=3000 v=0", i, bus.memReq,
                 bus.memAddr, bus.instValid);
      end
      tick();
    end
    man_ack = 1'b1;
    man_data = 16'h00AA;
    checks++; if (bus.instValid !== 1'b0) begin errors++; $display("FAIL lat_ackcycle got %b exp 0", bus.instValid); end
    tick();
    man_ack = 1'b0;
    checks++;
    if (bus.instValid !== 1'b1 || bus.instAddr !== 16'h3000 || bus.instData !== 16'h00AA) begin
      errors++;
      $display("FAIL lat_head got v=%b a=%h d=%h exp v=1 a=3000 d=00aa", bus.instValid, bus.instAddr, bus.instData);
    end
    checks++; if (bus.memAddr !== 16'h3001) begin errors++; $display("FAIL lat_next got %h exp 3001", bus.memAddr); end
  endtask

  task automatic test_redirect();
    bus.redirect = 1'b1;
    bus.redirectAddr = 16'h4000;
    tick();
    bus.redirect = 1'b0;
    checks++; if (bus.instValid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b exp 0", bus.instValid); end
    checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 16'h3001) begin
      errors++; $display("FAIL redir_stale got req=%b a=%h exp req=1 a=3001", bus.memReq, bus.memAddr); end
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL redir_drop got %0d exp 2", dbg_state); end
    tick();
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL redir_drop2 got %0d exp 2", dbg_state); end
    man_ack = 1'b1;
    man_data = 16'h1234;
    tick();
    man_ack = 1'b0;
    checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 16'h4000) begin
      errors++; $display("FAIL redir_newreq got req=%b a=%h exp req=1 a=4000", bus.memReq, bus.memAddr); end
    checks++; if (bus.instValid !== 1'b0) begin errors++; $display("FAIL redir_discard got %b exp 0", bus.instValid); end
    auto_ack = 1'b1;
    bus.instReady = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.instValid !== 1'b1 || bus.instAddr !== 16'h4000 + 16'(i) || bus.instData !== 16'h1000 + 16'(i)) begin
        errors++;
        $display("FAIL redir_head%0d got v=%b a=%h d=%h exp v=1 a=%h d=%h", i, bus.instValid,
                 bus.instAddr, bus.instData, 16'h4000 + 16'(i), 16'h1000 + 16'(i));
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a [3];
    exp_a[0] = 16'hFFFF;
    exp_a[1] = 16'h0000;
    exp_a[2] = 16'h0001;
    bus.redirect = 1'b1;
    bus.redirectAddr = 16'hFFFF;
    tick();
    bus.redirect = 1'b0;
    checks++; if (bus.memAddr !== 16'hFFFF || bus.instValid !== 1'b0) begin
      errors++; $display("FAIL wrap_start got a=%h v=%b exp a=ffff v=0", bus.memAddr, bus.instValid); end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.instValid !== 1'b1 || bus.instAddr !== exp_a[i] || bus.instData !== exp_a[i] - 16'h3000) begin
        errors++;
        $display("FAIL wrap_head%0d got v=%b a=%h d=%h exp v=1 a=%h d=%h", i, bus.instValid,
                 bus.instAddr, bus.instData, exp_a[i], exp_a[i] - 16'h3000);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    auto_ack = 1'b0;
    man_ack = 1'b0;
    bus.instReady = 1'b0;
    tick();
    checks++; if (bus.memReq !== 1'b1) begin errors++; $display("FAIL mid_wait got %b exp 1", bus.memReq); end
    rst = 1'b1;
    #1;
    checks++; if (bus.memReq !== 1'b0 || bus.instValid !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL mid_async got req=%b v=%b st=%0d exp 0 0 0", bus.memReq, bus.instValid, dbg_state); end
    man_ack = 1'b1;
    man_data = 16'hBEEF;
    tick();
    checks++; if (bus.memReq !== 1'b0 || bus.instValid !== 1'b0) begin
      errors++; $display("FAIL mid_inrst got req=%b v=%b exp 0 0", bus.memReq, bus.instValid); end
    rst = 1'b0;
    tick();
    man_ack = 1'b0;
    checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 16'h3000 || bus.instValid !== 1'b0) begin
      errors++; $display("FAIL mid_restart got req=%b a=%h v=%b exp 1 3000 0", bus.memReq, bus.memAddr, bus.instValid); end
    man_ack = 1'b1;
    man_data = 16'h5555;
    tick();
    man_ack = 1'b0;
    checks++; if (bus.instValid !== 1'b1 || bus.instAddr !== 16'h3000 || bus.instData !== 16'h5555) begin
      errors++; $display("FAIL mid_first got v=%b a=%h d=%h exp 1 3000 5555", bus.instValid, bus.instAddr, bus.instData); end
  endtask

  initial begin
    bus.instReady = 1'b0;
    bus.redirect = 1'b0;
    bus.redirectAddr = 16'h0000;
    test_reset();
    test_stream();
    test_backpressure();
    test_latency();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
